// File: rtl/io_in_conditioner.sv
// Input conditioning for the robot IO register block: a 2-FF synchronizer per pin,
// per-bit debounce, one-cycle rise/fall pulses and software-clearable sticky edge flags.
module io_in_conditioner #(
    parameter int WIDTH     = 32,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] pins_raw,
    input  logic [WIDTH-1:0] en_mask,
    input  logic [WIDTH-1:0] sticky_clr,
    output logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] edge_sticky,
    output logic             any_edge
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] io_q, io_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d = pins_raw;
        sync2_d = sync1_q;
        io_d    = io_q;
        for (int i = 0; i < WIDTH; i++) begin
            // Any cycle that is disabled or agrees with io_in restarts the count.
            cnt_d[i] = '0;
            if (en_mask[i] && (sync2_q[i] != io_q[i])) begin
                if (cnt_q[i] == CNT_MAX) begin
                    io_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d   = io_d & ~io_q;
        fall_d   = ~io_d & io_q;
        // A fresh edge overrides a simultaneous clear.
        sticky_d = (sticky_q & ~sticky_clr) | rise_d | fall_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            io_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            io_q     <= io_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io_in       = io_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign edge_sticky = sticky_q;
    assign any_edge    = |sticky_q;

endmodule

// File: tb/tb_io_in_conditioner.sv
// Bench for io_in_conditioner: three instances (DB_CYCLES 1, 4, 16) share stimulus and are
// compared every cycle against a behavioural run-length model, plus directed literal checks.
module tb_io_in_conditioner;

    localparam int NU = 3;
    localparam int DBV [NU] = '{1, 4, 16};

    logic        clk;
    logic        nrst;
    logic [31:0] pins;
    logic [31:0] en;
    logic [31:0] clr;

    logic [31:0] d_io   [NU];
    logic [31:0] d_rise [NU];
    logic [31:0] d_fall [NU];
    logic [31:0] d_st   [NU];
    logic        d_any  [NU];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        io_in_conditioner #(.WIDTH(32), .DB_CYCLES(DBV[g])) dut (
            .clk        (clk),
            .nrst       (nrst),
            .pins_raw   (pins),
            .en_mask    (en),
            .sticky_clr (clr),
            .io_in      (d_io[g]),
            .rise_pulse (d_rise[g]),
            .fall_pulse (d_fall[g]),
            .edge_sticky(d_st[g]),
            .any_edge   (d_any[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a pin value is accepted once it has disagreed with the accepted
    // value for db consecutive enabled samples, two register stages after the pin.
    logic [31:0] m_s1 [NU];
    logic [31:0] m_s2 [NU];
    logic [31:0] m_io [NU];
    logic [31:0] m_rise [NU];
    logic [31:0] m_fall [NU];
    logic [31:0] m_st [NU];
    int          m_run [NU][32];

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            m_s1[u] = '0; m_s2[u] = '0; m_io[u] = '0;
            m_rise[u] = '0; m_fall[u] = '0; m_st[u] = '0;
            for (int b = 0; b < 32; b++) m_run[u][b] = 0;
        end
    endtask

    task automatic model_step();
        logic [31:0] nio;
        for (int u = 0; u < NU; u++) begin
            nio = m_io[u];
            for (int b = 0; b < 32; b++) begin
                if (en[b] && (m_s2[u][b] != m_io[u][b])) begin
                    m_run[u][b] = m_run[u][b] + 1;
                    if (m_run[u][b] == DBV[u]) begin
                        nio[b] = m_s2[u][b];
                        m_run[u][b] = 0;
                    end
                end else begin
                    m_run[u][b] = 0;
                end
            end
            m_rise[u] = nio & ~m_io[u];
            m_fall[u] = ~nio & m_io[u];
            m_st[u]   = (m_st[u] & ~clr) | m_rise[u] | m_fall[u];
            m_io[u]   = nio;
            m_s2[u]   = m_s1[u];
            m_s1[u]   = pins;
        end
    endtask

    task automatic compare_all();
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("io_in db%0d", DBV[u]), d_io[u], m_io[u]);
            chk($sformatf("rise db%0d", DBV[u]), d_rise[u], m_rise[u]);
            chk($sformatf("fall db%0d", DBV[u]), d_fall[u], m_fall[u]);
            chk($sformatf("sticky db%0d", DBV[u]), d_st[u], m_st[u]);
            chk($sformatf("any_edge db%0d", DBV[u]), {31'b0, d_any[u]}, {31'b0, |m_st[u]});
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) model_reset();
            else model_step();
            #1;
            compare_all();
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] p);
        nrst = 1'b0;
        pins = p;
        wait_n(2);
        nrst = 1'b1;
        wait_n(4);
    endtask

    initial begin
        nrst = 1'b0;
        pins = '1;
        en   = '1;
        clr  = '0;
        wait_n(3);
        // Reset state
        chk("rst io4", d_io[1], 32'h0);
        chk("rst rise4", d_rise[1], 32'h0);
        chk("rst sticky4", d_st[1], 32'h0);
        chk("rst any4", {31'b0, d_any[1]}, 32'h0);

        // Release with all pins high: first capture edge k=1
        nrst = 1'b1;
        wait_n(2);
        chk("t1 io1 pre", d_io[0], 32'h0);
        wait_n(1);
        chk("t1 io1 k+2", d_io[0], 32'hFFFF_FFFF);
        wait_n(2);
        chk("t1 io4 pre", d_io[1], 32'h0);
        wait_n(1);
        chk("t1 io4 k+5", d_io[1], 32'hFFFF_FFFF);
        chk("t1 rise4", d_rise[1], 32'hFFFF_FFFF);
        wait_n(1);
        chk("t1 rise4 end", d_rise[1], 32'h0);
        chk("t1 sticky4", d_st[1], 32'hFFFF_FFFF);
        chk("t1 any4", {31'b0, d_any[1]}, 32'h1);
        clr = '1;
        wait_n(13);
        chk("t1 io16 k+17", d_io[2], 32'hFFFF_FFFF);
        chk("t1 sticky16 held clr", d_st[2], 32'h0);
        clr = '0;

        // Stable edge on bit 0
        do_reset(32'h0);
        pins = 32'h1;
        wait_n(3);
        chk("t2 io1", d_io[0], 32'h1);
        wait_n(2);
        chk("t2 io4 pre", d_io[1], 32'h0);
        wait_n(1);
        chk("t2 io4", d_io[1], 32'h1);
        chk("t2 rise4", d_rise[1], 32'h1);
        wait_n(1);
        chk("t2 rise4 end", d_rise[1], 32'h0);
        chk("t2 sticky4", d_st[1], 32'h1);
        chk("t2 any4", {31'b0, d_any[1]}, 32'h1);

        // Clear coinciding with a fall pulse
        pins = 32'h0;
        wait_n(5);
        clr = 32'h1;
        wait_n(1);
        chk("t4 fall4", d_fall[1], 32'h1);
        chk("t4 sticky4 collide", d_st[1], 32'h1);
        wait_n(1);
        chk("t4 sticky4 cleared", d_st[1], 32'h0);
        chk("t4 any4", {31'b0, d_any[1]}, 32'h0);
        clr = 32'h0;

        // Three-cycle glitch on bit 3
        pins = 32'h8;
        wait_n(3);
        pins = 32'h0;
        wait_n(10);
        chk("t3 io4 bit3", d_io[1] & 32'h8, 32'h0);
        chk("t3 sticky4 bit3", d_st[1] & 32'h8, 32'h0);
        chk("t3 any4", {31'b0, d_any[1]}, 32'h0);

        // Enable mask on bit 5
        en   = ~32'h20;
        pins = 32'h20;
        wait_n(20);
        chk("t5 io4 frozen", d_io[1] & 32'h20, 32'h0);
        en = '1;
        wait_n(3);
        chk("t5 io4 3rd", d_io[1] & 32'h20, 32'h0);
        wait_n(1);
        chk("t5 io4 4th", d_io[1] & 32'h20, 32'h20);
        chk("t5 rise4", d_rise[1], 32'h20);
        wait_n(1);
        chk("t5 rise4 end", d_rise[1], 32'h0);

        // Reset mid-count on the DB_CYCLES=16 instance
        do_reset(32'h0);
        pins = 32'h80;
        wait_n(12);
        chk("t6 io16 counting", d_io[2], 32'h0);
        nrst = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("t6 rst io db%0d", DBV[u]), d_io[u], 32'h0);
            chk($sformatf("t6 rst sticky db%0d", DBV[u]), d_st[u], 32'h0);
            chk($sformatf("t6 rst any db%0d", DBV[u]), {31'b0, d_any[u]}, 32'h0);
        end
        wait_n(2);
        nrst = 1'b1;
        wait_n(17);
        chk("t6 io16 pre", d_io[2], 32'h0);
        wait_n(1);
        chk("t6 io16 k+17", d_io[2], 32'h80);
        chk("t6 rise16", d_rise[2], 32'h80);
        wait_n(1);
        chk("t6 rise16 end", d_rise[2], 32'h0);
        chk("t6 any16", {31'b0, d_any[2]}, 32'h1);

        wait_n(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_in_conditioner.md
Name: io_in_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the memory-mapped robot IO register block and drives that block's 32-bit IO_in bus.
- Each raw external pin gets a 2-FF synchronizer and a per-bit debounce filter.
- Generates one-cycle rise/fall pulses, plus sticky edge flags that software clears through a clear mask.
- `any_edge` provides a single summary line for polling or an interrupt.

Parameters:
- WIDTH, 32, number of input pins; must match the IO register block's IO_in width.
- DB_CYCLES, 16, consecutive cycles the synchronized value must differ from the debounced value before it is accepted; legal range 1..65535.
- CNT_W, $clog2(DB_CYCLES+1), derived width of the per-bit debounce counter; never overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- nrst  input  1  asynchronous active-low reset
- pins_raw  input  WIDTH  raw asynchronous pin levels
- en_mask  input  WIDTH  per-bit enable; 0 freezes that bit
- sticky_clr  input  WIDTH  per-bit clear for edge_sticky, level-sensitive, sampled each edge
- io_in  output  WIDTH  debounced pin levels; connects to the IO register block's IO_in
- rise_pulse  output  WIDTH  one-cycle pulse on debounced 0->1
- fall_pulse  output  WIDTH  one-cycle pulse on debounced 1->0
- edge_sticky  output  WIDTH  latched "edge occurred" flags
- any_edge  output  1  OR-reduction of edge_sticky

Behaviour:

Reset:
- nrst low asynchronously clears: sync1, sync2, io_in, all counters, rise_pulse, fall_pulse, edge_sticky. any_edge is therefore 0.
- Reset asserted mid-count discards any partial count.
- After release, first capture occurs on the next rising edge.

Synchronizer:
- sync1 <= pins_raw; sync2 <= sync1, every edge for every bit, regardless of en_mask.

Debounce (per bit i, registered):
- en_mask[i]=0: cnt[i] <= 0, io_in[i] holds, no pulses.
- en_mask[i]=1 and sync2[i]==io_in[i]: cnt[i] <= 0 (a glitch restarts the count).
- en_mask[i]=1, sync2[i]!=io_in[i], cnt[i]<DB_CYCLES-1: cnt[i] <= cnt[i]+1.
- en_mask[i]=1, sync2[i]!=io_in[i], cnt[i]==DB_CYCLES-1: io_in[i] <= sync2[i]; cnt[i] <= 0.
- Counter never exceeds DB_CYCLES-1; no wrap.

Latency:
- A pin level first sampled into sync1 at edge k, and held stable, appears on io_in at edge k+DB_CYCLES+1.
- With DB_CYCLES=1, that is edge k+2.
- When a held, differing bit is re-enabled, io_in flips on the DB_CYCLES-th enabled edge.

Pulses (registered alongside io_in):
- rise_pulse[i] is 1 for exactly the cycle in which io_in[i] first shows 1 after 0.
- fall_pulse[i] is the mirror case (first shows 0 after 1).
- Both pulses are 0 in every other cycle.
- rise_pulse and fall_pulse are never simultaneously 1 for the same bit.

Sticky flags:
- edge_sticky[i] <= (edge_sticky[i] & ~sticky_clr[i]) | rise_next[i] | fall_next[i].
- A new edge in the same cycle as a clear wins: the flag stays 1.
- Holding sticky_clr high keeps the flag clear except in cycles where an edge arrives.

Summary:
- any_edge is combinational: |edge_sticky.

General:
- Bits are fully independent; no cross-bit interaction.
- No combinational path from any input to any output except edge_sticky -> any_edge.

Test Plan:
1. Reset: nrst=0 with pins_raw=32'hFFFFFFFF -> all outputs 0. Release nrst and hold pins -> io_in=32'hFFFFFFFF at edge DB_CYCLES+1 after the first capture edge; rise_pulse=32'hFFFFFFFF for one cycle.
2. Stable edge (DB_CYCLES=4, en_mask all 1): pins_raw[0] 0->1, sampled at edge k -> io_in[0]=1 at edge k+5; rise_pulse[0] high one cycle only; edge_sticky[0]=1; any_edge=1.
3. Glitch (DB_CYCLES=4): pins_raw[3] high for 3 cycles, then low for 10 -> io_in[3] stays 0; no pulses; edge_sticky[3]=0.
4. Clear collision: edge_sticky[0]=1; pins_raw[0] 1->0 timed so fall_pulse[0] coincides with sticky_clr[0]=1 -> edge_sticky[0] stays 1. Next cycle sticky_clr[0]=1 with no edge -> 0; any_edge=0.
5. Enable mask (DB_CYCLES=4): en_mask[5]=0; pins_raw[5]=1 for 20 cycles -> io_in[5]=0, no pulse. Set en_mask[5]=1 -> io_in[5]=1 on the 4th enabled edge, with one rise_pulse[5].
6. Reset mid-count (DB_CYCLES=16): pins_raw[7] 0->1; assert nrst at count 10 -> outputs clear immediately. Release with pin still 1 -> io_in[7] rises a full 17 edges after the first post-reset capture.
